// File: rtl/alu_share_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl_pkg
// Shared constants and types for the ALU sharing controller.
//   NUM_Threads : default number of hardware threads (existing constant)
//   NUM_ALUS    : default number of shared execute ALUs
//   LONG_LAT    : default reservation length of a long op, in cycles
//   alu_idx_t   : ALU index type for the default ALU count
//   wrap_inc    : modulo-n increment used for the round-robin pointer
// ---------------------------------------------------------------------------
package alu_share_ctrl_pkg;

    localparam int NUM_Threads = 4;
    localparam int NUM_ALUS    = 3;
    localparam int LONG_LAT    = 3;

    localparam int ALU_IDX_W = (NUM_ALUS > 1) ? $clog2(NUM_ALUS) : 1;

    typedef logic [ALU_IDX_W-1:0] alu_idx_t;

    // Increment idx and wrap back to 0 at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        int unsigned nxt;
        nxt = idx + 32'd1;
        if (nxt >= n) begin
            nxt = 32'd0;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage : alu_share_ctrl_pkg

// File: rtl/alu_share_ctrl_rr_pick.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl_rr_pick
// Combinational rotating-priority finder. Lists thread indices in scan order
// starting at ptr and flags which positions hold a candidate.
// Ports:
//   cand    in  N            candidate vector, one bit per thread
//   ptr     in  PW           thread index that has top priority
//   ord_vld out N            ord_vld[p]=1 when the p-th thread in scan order is a candidate
//   ord_idx out N x PW       thread index at scan position p
// ---------------------------------------------------------------------------
module alu_share_ctrl_rr_pick #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]         cand,
    input  logic [PW-1:0]        ptr,
    output logic [N-1:0]         ord_vld,
    output logic [N-1:0][PW-1:0] ord_idx
);

    logic [PW-1:0] idx_s;

    // Rotate the thread order so position 0 is ptr.
    always_comb begin
        idx_s   = '0;
        ord_vld = '0;
        ord_idx = '0;
        for (int p = 0; p < N; p++) begin
            idx_s      = PW'((int'(ptr) + p) % N);
            ord_idx[p] = idx_s;
            ord_vld[p] = cand[idx_s];
        end
    end

endmodule : alu_share_ctrl_rr_pick

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
// Shares NUM_ALUS execute ALUs among NUM_THREADS threads with round-robin
// arbitration and drives the per-thread IF/ID hold vector. Long ops keep
// their ALU for LONG_LAT cycles. Grant, hold and ALU index are combinational
// from registered state plus current inputs so hold settles before the
// IF/ID capture edge.
// Ports:
//   clk       in  1                    clock
//   rst       in  1                    asynchronous active-low reset
//   req       in  NUM_THREADS          thread has an ALU op in ID
//   is_long   in  NUM_THREADS          op is multi-cycle (used on grant cycle)
//   ext_hold  in  NUM_THREADS          other stall source per thread
//   flush     in  NUM_THREADS          kill thread op, release its ALU
//   gnt       out NUM_THREADS          thread owns an ALU this cycle
//   alu_id    out NUM_THREADS x AW     ALU index per thread (0 when no grant)
//   hold      out NUM_THREADS          hold to IF/ID pipeline registers
//   stall_cnt out NUM_THREADS x 16     losing-candidate cycle counters
//                                      (only with ALU_SHARE_STATS_EN defined)
// Optional feature macro: ALU_SHARE_STATS_EN
// ---------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter  int NUM_THREADS = alu_share_ctrl_pkg::NUM_Threads,
    parameter  int NUM_ALUS    = alu_share_ctrl_pkg::NUM_ALUS,
    parameter  int LONG_LAT    = alu_share_ctrl_pkg::LONG_LAT,
    localparam int AW          = (NUM_ALUS > 1) ? $clog2(NUM_ALUS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_THREADS-1:0]         req,
    input  logic [NUM_THREADS-1:0]         is_long,
    input  logic [NUM_THREADS-1:0]         ext_hold,
    input  logic [NUM_THREADS-1:0]         flush,
    output logic [NUM_THREADS-1:0]         gnt,
    output logic [NUM_THREADS-1:0][AW-1:0] alu_id,
    output logic [NUM_THREADS-1:0]         hold
`ifdef ALU_SHARE_STATS_EN
    ,
    output logic [NUM_THREADS-1:0][15:0]   stall_cnt
`endif
);

    import alu_share_ctrl_pkg::*;

    localparam int   TW      = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int   CW      = $clog2(LONG_LAT + 1);
    localparam logic LONG_EN = (LONG_LAT > 1);

    // Registered state
    logic [TW-1:0] rr_ptr_r;
    logic [CW-1:0] cnt_r   [NUM_ALUS];
    logic [TW-1:0] owner_r [NUM_ALUS];

    // Ownership view of the reservations
    logic [NUM_THREADS-1:0]         busy_s;
    logic [NUM_THREADS-1:0]         own_multi_s;
    logic [NUM_THREADS-1:0][AW-1:0] own_alu_s;
    logic [NUM_ALUS-1:0]            free_s;

    // Arbitration
    logic [NUM_THREADS-1:0]         cand_s;
    logic [NUM_THREADS-1:0]         ord_vld_s;
    logic [NUM_THREADS-1:0][TW-1:0] ord_idx_s;
    logic [NUM_ALUS-1:0]            avail_s;
    logic                           found_s;
    logic [NUM_THREADS-1:0]         new_gnt_s;
    logic [NUM_THREADS-1:0][AW-1:0] new_alu_s;
    logic [TW-1:0]                  last_s;
    logic                           any_s;
    logic [NUM_ALUS-1:0]            alu_long_s;
    logic [TW-1:0]                  alu_thr_s [NUM_ALUS];

    // Decode which thread holds which reserved ALU; cnt==0 means free.
    always_comb begin
        busy_s      = '0;
        own_multi_s = '0;
        own_alu_s   = '0;
        free_s      = '0;
        for (int k = 0; k < NUM_ALUS; k++) begin
            if (cnt_r[k] == '0) begin
                free_s[k] = 1'b1;
            end else begin
                for (int i = 0; i < NUM_THREADS; i++) begin
                    if (owner_r[k] == TW'(i)) begin
                        busy_s[i]      = 1'b1;
                        own_alu_s[i]   = AW'(k);
                        own_multi_s[i] = (cnt_r[k] > CW'(1));
                    end else begin
                        own_multi_s[i] = own_multi_s[i];
                    end
                end
            end
        end
    end

    assign cand_s = req & ~ext_hold & ~flush & ~busy_s;

    alu_share_ctrl_rr_pick #(
        .N (NUM_THREADS)
    ) u_rr_pick (
        .cand    (cand_s),
        .ptr     (rr_ptr_r),
        .ord_vld (ord_vld_s),
        .ord_idx (ord_idx_s)
    );

    // Walk candidates in scan order; each takes the lowest free ALU left.
    always_comb begin
        avail_s    = free_s;
        found_s    = 1'b0;
        new_gnt_s  = '0;
        new_alu_s  = '0;
        last_s     = rr_ptr_r;
        any_s      = 1'b0;
        alu_long_s = '0;
        for (int k = 0; k < NUM_ALUS; k++) begin
            alu_thr_s[k] = '0;
        end
        for (int p = 0; p < NUM_THREADS; p++) begin
            found_s = 1'b0;
            if (ord_vld_s[p]) begin
                for (int k = 0; k < NUM_ALUS; k++) begin
                    if (!found_s && avail_s[k]) begin
                        found_s                  = 1'b1;
                        avail_s[k]               = 1'b0;
                        new_gnt_s[ord_idx_s[p]]  = 1'b1;
                        new_alu_s[ord_idx_s[p]]  = AW'(k);
                        last_s                   = ord_idx_s[p];
                        any_s                    = 1'b1;
                        alu_long_s[k]            = LONG_EN & is_long[ord_idx_s[p]];
                        alu_thr_s[k]             = ord_idx_s[p];
                    end else begin
                        found_s = found_s;
                    end
                end
            end else begin
                found_s = 1'b0;
            end
        end
    end

    // Per-thread outputs; flush wins over everything, reset forces zeros.
    always_comb begin
        gnt    = '0;
        alu_id = '0;
        hold   = '0;
        if (rst) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (flush[i]) begin
                    gnt[i]  = 1'b0;
                    hold[i] = 1'b0;
                end else if (busy_s[i]) begin
                    gnt[i]    = 1'b1;
                    alu_id[i] = own_alu_s[i];
                    hold[i]   = own_multi_s[i] | ext_hold[i];
                end else if (new_gnt_s[i]) begin
                    gnt[i]    = 1'b1;
                    alu_id[i] = new_alu_s[i];
                    hold[i]   = LONG_EN & is_long[i];
                end else begin
                    // A requester that is not granted is either a loser or
                    // externally held; both stall. No request: ext_hold only.
                    hold[i] = req[i] | ext_hold[i];
                end
            end
        end else begin
            gnt = '0;
        end
    end

    // Round-robin pointer and reservation counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r <= '0;
            for (int k = 0; k < NUM_ALUS; k++) begin
                cnt_r[k]   <= '0;
                owner_r[k] <= '0;
            end
        end else begin
            if (any_s) begin
                rr_ptr_r <= TW'(wrap_inc(32'(last_s), NUM_THREADS));
            end
            for (int k = 0; k < NUM_ALUS; k++) begin
                if (cnt_r[k] != '0) begin
                    // Counting continues through ext_hold; only flush cuts it short.
                    if (flush[owner_r[k]]) begin
                        cnt_r[k] <= '0;
                    end else begin
                        cnt_r[k] <= cnt_r[k] - CW'(1);
                    end
                end else if (alu_long_s[k]) begin
                    cnt_r[k]   <= CW'(LONG_LAT - 1);
                    owner_r[k] <= alu_thr_s[k];
                end
            end
        end
    end

`ifdef ALU_SHARE_STATS_EN
    logic [NUM_THREADS-1:0] losing_s;

    assign losing_s = cand_s & ~new_gnt_s;

    // Saturating count of cycles each thread lost arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (losing_s[i] && (stall_cnt[i] != 16'hFFFF)) begin
                    stall_cnt[i] <= stall_cnt[i] + 16'd1;
                end
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule : alu_share_ctrl

// File: tb/tb_alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_share_ctrl
// Directed bench for alu_share_ctrl (4 threads, 3 ALUs, LONG_LAT=3).
// Inputs change on the falling edge; outputs are checked 1 time unit later,
// well before the next rising edge. alu_id is compared as {T3,T2,T1,T0}.
// ---------------------------------------------------------------------------
module tb_alu_share_ctrl;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [3:0]       is_long;
    logic [3:0]       ext_hold;
    logic [3:0]       flush;
    logic [3:0]       gnt;
    logic [3:0][1:0]  alu_id;
    logic [3:0]       hold;
`ifdef ALU_SHARE_STATS_EN
    logic [3:0][15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    alu_share_ctrl #(
        .NUM_THREADS (4),
        .NUM_ALUS    (3),
        .LONG_LAT    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .is_long   (is_long),
        .ext_hold  (ext_hold),
        .flush     (flush),
        .gnt       (gnt),
        .alu_id    (alu_id),
        .hold      (hold)
`ifdef ALU_SHARE_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] eg,
                              input logic [7:0] ea, input logic [3:0] eh);
        check_eq({tag, ".gnt"},    32'(gnt),    32'(eg));
        check_eq({tag, ".alu_id"}, 32'(alu_id), 32'(ea));
        check_eq({tag, ".hold"},   32'(hold),   32'(eh));
    endtask

    // Drive one cycle of inputs at the falling edge and check the outputs.
    task automatic step(input string tag,
                        input logic [3:0] r, input logic [3:0] l,
                        input logic [3:0] e, input logic [3:0] f,
                        input logic [3:0] eg, input logic [7:0] ea, input logic [3:0] eh);
        @(negedge clk);
        req      = r;
        is_long  = l;
        ext_hold = e;
        flush    = f;
        #1;
        check_outs(tag, eg, ea, eh);
    endtask

    initial begin
        rst      = 1'b0;
        req      = 4'b1111;
        is_long  = 4'b0000;
        ext_hold = 4'b0000;
        flush    = 4'b0000;
        #12;
        check_outs("reset", 4'b0000, 8'h00, 4'b0000);
        @(negedge clk);
        req = 4'b0000;
        rst = 1'b1;

        //    tag        req      long     ext      flush    gnt      alu_id hold
        step("rr_c1",    4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 8'h24, 4'b1000);
        step("rr_c2",    4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1011, 8'h09, 4'b0100);
        step("idle_ext", 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 8'h00, 4'b0010);
        // T0 long at t; ext_hold[0] asserted at t+2 and t+3
        step("long_t0",  4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 8'h00, 4'b0001);
        step("long_t1",  4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 8'h24, 4'b1001);
        step("long_t2",  4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b1011, 8'h48, 4'b0101);
        step("long_t3",  4'b1110, 4'b0000, 4'b0001, 4'b0000, 4'b1110, 8'h48, 4'b0001);
        step("to_ptr0",  4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 8'h00, 4'b0000);
        // Three long ops, T3 starved until the fourth cycle
        step("three_c1", 4'b1111, 4'b0111, 4'b0000, 4'b0000, 4'b0111, 8'h24, 4'b1111);
        step("three_c2", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 8'h24, 4'b1111);
        step("three_c3", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 8'h24, 4'b1000);
        step("three_c4", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1011, 8'h09, 4'b0100);
        step("ext_skip", 4'b1111, 4'b0000, 4'b0010, 4'b0000, 4'b1101, 8'h42, 4'b0010);
        // Flush of a long op on its second cycle
        step("fl_t0",    4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 8'h00, 4'b0001);
        step("fl_t1",    4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0110, 8'h24, 4'b1000);
        step("fl_t2",    4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 8'h00, 4'b0000);
        // Reset in the middle of a long op
        step("rst_long", 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 8'h00, 4'b0010);
        @(posedge clk);
        #2;
        rst     = 1'b0;
        req     = 4'b1111;
        is_long = 4'b0000;
        #1;
        check_outs("rst_mid", 4'b0000, 8'h00, 4'b0000);
        @(posedge clk);
        #2;
        rst = 1'b1;
        step("post_rst", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 8'h24, 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu_share_ctrl
